// File: rtl/car_motion_controller.sv
// Single-car elevator motion controller: merges central assignments and
// in-car buttons into a pending-floor vector and sequences travel and door stops.
module car_motion_controller #(
  parameter int unsigned NUM_FLOORS    = 11,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  assign_valid,
  input  logic [3:0]            assign_floor,
  input  logic [NUM_FLOORS-1:0] req_in_lift,
  output logic [3:0]            cur_floor,
  output logic [1:0]            motor_signal,
  output logic                  door_open,
  output logic                  served_valid,
  output logic [3:0]            served_floor,
  output logic                  assign_err
);

  localparam int unsigned FW  = 4;
  localparam int unsigned TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_UP   = 2'b01;
  localparam logic [1:0] S_DOWN = 2'b10;
  localparam logic [1:0] S_DOOR = 2'b11;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  localparam logic [FW-1:0]  TOP_FLOOR   = FW'(NUM_FLOORS - 1);
  localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);

  // state and output registers
  logic [1:0]            r_state;
  logic [FW-1:0]         r_cur_floor;
  logic [NUM_FLOORS-1:0] r_pend;
  logic [TCW-1:0]        r_travel_cnt;
  logic [DCW-1:0]        r_door_cnt;
  logic                  r_dir_up;
  logic [1:0]            r_motor;
  logic                  r_door_open;
  logic                  r_served_valid;
  logic [FW-1:0]         r_served_floor;
  logic                  r_assign_err;

  // combinational request view and next-state values
  logic                  w_assign_ok;
  logic [NUM_FLOORS-1:0] w_assign_oh;
  logic [NUM_FLOORS-1:0] w_new;
  logic [NUM_FLOORS-1:0] w_pc;
  logic                  w_pc_cur;
  logic                  w_new_cur;
  logic                  w_gt_cur;
  logic                  w_lt_cur;
  logic                  w_ge_cur;
  logic                  w_le_cur;
  logic                  w_pc_up;
  logic                  w_gt_up;
  logic                  w_pc_dn;
  logic                  w_lt_dn;

  logic [1:0]            w_state_nxt;
  logic [FW-1:0]         w_floor_nxt;
  logic [TCW-1:0]        w_travel_nxt;
  logic [DCW-1:0]        w_door_nxt;
  logic                  w_dir_nxt;
  logic                  w_serve;
  logic [FW-1:0]         w_serve_floor;
  logic                  w_clear_en;
  logic [FW-1:0]         w_clear_floor;
  logic [NUM_FLOORS-1:0] w_pend_nxt;

  // Merge this cycle's assignment (if in range) with the car buttons.
  always_comb begin
    w_assign_ok = assign_valid && ({1'b0, assign_floor} < 5'(NUM_FLOORS));
    w_assign_oh = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      w_assign_oh[i] = w_assign_ok && (assign_floor == FW'(i));
    end
    w_new = req_in_lift | w_assign_oh;
    w_pc  = r_pend | w_new;
  end

  // Summaries of pending requests relative to the current and adjacent floors.
  always_comb begin
    w_pc_cur  = 1'b0;
    w_new_cur = 1'b0;
    w_gt_cur  = 1'b0;
    w_lt_cur  = 1'b0;
    w_ge_cur  = 1'b0;
    w_le_cur  = 1'b0;
    w_pc_up   = 1'b0;
    w_gt_up   = 1'b0;
    w_pc_dn   = 1'b0;
    w_lt_dn   = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (i == int'(r_cur_floor))     w_pc_cur  = w_pc_cur  | w_pc[i];
      if (i == int'(r_cur_floor))     w_new_cur = w_new_cur | w_new[i];
      if (i >  int'(r_cur_floor))     w_gt_cur  = w_gt_cur  | w_pc[i];
      if (i <  int'(r_cur_floor))     w_lt_cur  = w_lt_cur  | w_pc[i];
      if (i >= int'(r_cur_floor))     w_ge_cur  = w_ge_cur  | w_pc[i];
      if (i <= int'(r_cur_floor))     w_le_cur  = w_le_cur  | w_pc[i];
      if (i == int'(r_cur_floor) + 1) w_pc_up   = w_pc_up   | w_pc[i];
      if (i >  int'(r_cur_floor) + 1) w_gt_up   = w_gt_up   | w_pc[i];
      if (i == int'(r_cur_floor) - 1) w_pc_dn   = w_pc_dn   | w_pc[i];
      if (i <  int'(r_cur_floor) - 1) w_lt_dn   = w_lt_dn   | w_pc[i];
    end
  end

  // Next-state, floor stepping, counters, service and pending-clear decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_cur_floor;
    w_travel_nxt  = r_travel_cnt;
    w_door_nxt    = r_door_cnt;
    w_dir_nxt     = r_dir_up;
    w_serve       = 1'b0;
    w_serve_floor = r_cur_floor;
    w_clear_en    = 1'b0;
    w_clear_floor = r_cur_floor;

    case (r_state)
      S_IDLE: begin
        w_travel_nxt = '0;
        if (w_pc_cur) begin
          w_state_nxt = S_DOOR;
          w_door_nxt  = '0;
          w_serve     = 1'b1;
          w_clear_en  = 1'b1;
        end else if (w_gt_cur && (r_cur_floor != TOP_FLOOR)) begin
          w_state_nxt = S_UP;
          w_dir_nxt   = 1'b1;
        end else if (w_lt_cur && (r_cur_floor != '0)) begin
          w_state_nxt = S_DOWN;
          w_dir_nxt   = 1'b0;
        end
      end

      S_UP: begin
        if (r_travel_cnt == TRAVEL_LAST) begin
          w_travel_nxt = '0;
          if (r_cur_floor != TOP_FLOOR) begin
            w_floor_nxt = r_cur_floor + 4'd1;
            if (w_pc_up) begin
              w_state_nxt   = S_DOOR;
              w_door_nxt    = '0;
              w_serve       = 1'b1;
              w_serve_floor = r_cur_floor + 4'd1;
              w_clear_en    = 1'b1;
              w_clear_floor = r_cur_floor + 4'd1;
            end else if (w_gt_up) begin
              w_state_nxt = S_UP;
            end else if (w_le_cur) begin
              w_state_nxt = S_DOWN;
              w_dir_nxt   = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_travel_nxt = r_travel_cnt + TCW'(1);
        end
      end

      S_DOWN: begin
        if (r_travel_cnt == TRAVEL_LAST) begin
          w_travel_nxt = '0;
          if (r_cur_floor != '0) begin
            w_floor_nxt = r_cur_floor - 4'd1;
            if (w_pc_dn) begin
              w_state_nxt   = S_DOOR;
              w_door_nxt    = '0;
              w_serve       = 1'b1;
              w_serve_floor = r_cur_floor - 4'd1;
              w_clear_en    = 1'b1;
              w_clear_floor = r_cur_floor - 4'd1;
            end else if (w_lt_dn) begin
              w_state_nxt = S_DOWN;
            end else if (w_ge_cur) begin
              w_state_nxt = S_UP;
              w_dir_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_travel_nxt = r_travel_cnt + TCW'(1);
        end
      end

      S_DOOR: begin
        // a press for this floor never latches; it only holds the door
        w_clear_en = 1'b1;
        if (w_new_cur) begin
          w_door_nxt = '0;
          w_serve    = 1'b1;
        end else if (r_door_cnt == DOOR_LAST) begin
          w_door_nxt = '0;
          if (r_dir_up && w_gt_cur) begin
            w_state_nxt = S_UP;
          end else if (!r_dir_up && w_lt_cur) begin
            w_state_nxt = S_DOWN;
          end else if (w_gt_cur) begin
            w_state_nxt = S_UP;
            w_dir_nxt   = 1'b1;
          end else if (w_lt_cur) begin
            w_state_nxt = S_DOWN;
            w_dir_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_door_nxt = r_door_cnt + DCW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch every new request except the floor being (or about to be) served.
  always_comb begin
    w_pend_nxt = w_pc;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (w_clear_en && (w_clear_floor == FW'(i))) w_pend_nxt[i] = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cur_floor    <= '0;
      r_pend         <= '0;
      r_travel_cnt   <= '0;
      r_door_cnt     <= '0;
      r_dir_up       <= 1'b1;
      r_motor        <= MOTOR_STOP;
      r_door_open    <= 1'b0;
      r_served_valid <= 1'b0;
      r_served_floor <= '0;
      r_assign_err   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cur_floor    <= w_floor_nxt;
      r_pend         <= w_pend_nxt;
      r_travel_cnt   <= w_travel_nxt;
      r_door_cnt     <= w_door_nxt;
      r_dir_up       <= w_dir_nxt;
      r_motor        <= (w_state_nxt == S_UP)   ? MOTOR_UP :
                        (w_state_nxt == S_DOWN) ? MOTOR_DOWN : MOTOR_STOP;
      r_door_open    <= (w_state_nxt == S_DOOR);
      r_served_valid <= w_serve;
      if (w_serve) r_served_floor <= w_serve_floor;
      r_assign_err   <= assign_valid && !w_assign_ok;
    end
  end

  assign cur_floor    = r_cur_floor;
  assign motor_signal = r_motor;
  assign door_open    = r_door_open;
  assign served_valid = r_served_valid;
  assign served_floor = r_served_floor;
  assign assign_err   = r_assign_err;

endmodule
